// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the single-beat AXI write master:
//   - state_t : FSM state encoding (IDLE, ADDR_DATA, RESP, DONE)
//   - OKAY / EXOKAY / SLVERR / DECERR : AXI write response codes
//   - is_busy_state() : states in which a transaction is in flight
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ADDR_DATA = 2'b01,
        RESP      = 2'b10,
        DONE      = 2'b11
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Any state other than IDLE holds an accepted command.
    function automatic logic is_busy_state(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// ---------------------------------------------------------------------------
// axi_write_master_if
// AXI write-path channels (AW, W, B) for a single-beat master.
//   master modport : drives AWADDR/AWVALID, WDATA/WSTRB/WVALID, BREADY
//                    samples AWREADY, WREADY, BVALID/BRESP
//   slave modport  : the mirror image
// Parameters: ADDR_W (address width), DATA_W (data width, strobe = DATA_W/8).
// ---------------------------------------------------------------------------
interface axi_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic                BVALID;
    logic [1:0]          BRESP;
    logic                BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_timeout_cnt.sv
// ---------------------------------------------------------------------------
// axi_timeout_cnt
// Watchdog for the write master. Counts enabled ACLK edges after a clear
// and flags expiry once the count reaches TIMEOUT_CYCLES (saturates there).
// Ports: ACLK, ARESET (async active-low), clear (restart from zero, wins
//        over enable), enable (count this edge), expired (count == limit).
// ---------------------------------------------------------------------------
module axi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r;

    // Watchdog count: cleared on a new transaction, saturating at LIMIT.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LIMIT);
endmodule

// File: rtl/axi_write_master.sv
// ---------------------------------------------------------------------------
// axi_write_master
// Single-outstanding, single-beat AXI write master. A command accepted in
// IDLE is issued on AW and W concurrently; each channel drops its VALID
// independently after its handshake; once both are done the B response is
// collected and reported with a one-cycle done pulse.
// Ports: ACLK, ARESET (async active-low);
//        cmd_valid/cmd_ready/cmd_addr/cmd_data/cmd_strb : command request;
//        done (1-cycle pulse), resp (held completion code), busy;
//        axi : axi_write_master_if.master (AW/W/B channels).
// Optional: define AXI_WRITE_MASTER_TIMEOUT_EN to add a watchdog that aborts
//           a stalled transaction after TIMEOUT_CYCLES with resp = SLVERR.
// ---------------------------------------------------------------------------
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                done,
    output logic [1:0]          resp,
    output logic                busy,
    axi_write_master_if.master  axi
);
    state_t              state_r;
    logic [ADDR_W-1:0]   awaddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wstrb_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                bready_r;
    logic                cmd_ready_r;
    logic                done_r;
    logic [1:0]          resp_r;
    logic                busy_r;

    logic                capture_s;
    logic                aw_fin_s;
    logic                w_fin_s;
    logic                timeout_s;

    assign capture_s = (state_r == IDLE) && cmd_ready_r && cmd_valid;
    // A channel is finished if it already dropped VALID or handshakes now.
    assign aw_fin_s  = !awvalid_r || axi.AWREADY;
    assign w_fin_s   = !wvalid_r  || axi.WREADY;

`ifdef AXI_WRITE_MASTER_TIMEOUT_EN
    axi_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .clear   (capture_s),
        .enable  ((state_r == ADDR_DATA) || (state_r == RESP)),
        .expired (timeout_s)
    );
`else
    // Watchdog compiled out: a stalled slave is waited on indefinitely.
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_r     <= IDLE;
            awaddr_r    <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b0;
            resp_r      <= OKAY;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (capture_s) begin
                        awaddr_r    <= cmd_addr;
                        wdata_r     <= cmd_data;
                        wstrb_r     <= cmd_strb;
                        awvalid_r   <= 1'b1;
                        wvalid_r    <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ADDR_DATA;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ADDR_DATA: begin
                    if (timeout_s) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        resp_r    <= SLVERR;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        if (awvalid_r && axi.AWREADY) begin
                            awvalid_r <= 1'b0;
                        end
                        if (wvalid_r && axi.WREADY) begin
                            wvalid_r <= 1'b0;
                        end
                        if (aw_fin_s && w_fin_s) begin
                            bready_r <= 1'b1;
                            state_r  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (timeout_s) begin
                        bready_r <= 1'b0;
                        resp_r   <= SLVERR;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else if (axi.BVALID) begin
                        bready_r <= 1'b0;
                        resp_r   <= axi.BRESP;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= RESP;
                    end
                end
                DONE: begin
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign done        = done_r;
    assign resp        = resp_r;
    assign busy        = busy_r && is_busy_state(state_r);
    assign axi.AWADDR  = awaddr_r;
    assign axi.AWVALID = awvalid_r;
    assign axi.WDATA   = wdata_r;
    assign axi.WSTRB   = wstrb_r;
    assign axi.WVALID  = wvalid_r;
    assign axi.BREADY  = bready_r;
endmodule
